// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts rising edges of an asynchronous ring oscillator
// output over a fixed gate window and reports one count per tap.
// Optional feature macro: RING_METER_SWEEP_EN enables the 16-tap sweep mode.
// When it is undefined, the sweep input is ignored and only single-tap
// measurement is built; the port list is the same either way.
module ring_freq_meter #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               sweep,
  input  logic [3:0]         tap_sel,
  input  logic               ring_in,
  output logic               ring_ena,
  output logic [3:0]         ring_tap,
  output logic               busy,
  output logic               result_valid,
  output logic [3:0]         result_tap,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_ovf
);

  localparam int unsigned PH_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] GATE_LAST   = PH_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           tap_q, tap_d;
  logic                 ena_q, ena_d;
  logic                 busy_q, busy_d;
  logic                 rvalid_q, rvalid_d;
  logic [3:0]           rtap_q, rtap_d;
  logic [COUNT_W-1:0]   rcount_q, rcount_d;
  logic                 rovf_q, rovf_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 edge_det;
  logic [COUNT_W-1:0]   cnt_next;
  logic                 ovf_next;

`ifdef RING_METER_SWEEP_EN
  logic                 sweep_q, sweep_d;
`else
  logic                 unused_sweep;
  assign unused_sweep = sweep;
`endif

  assign edge_det = s2_q & ~s3_q;

  // Saturating edge counter value for the current cycle
  always_comb begin
    cnt_next = cnt_q;
    ovf_next = ovf_q;
    if (edge_det) begin
      if (cnt_q == '1) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_q + COUNT_W'(1);
      end
    end
  end

  // Next-state and registered-output logic; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    tap_d    = tap_q;
    ena_d    = ena_q;
    busy_d   = busy_q;
    rvalid_d = 1'b0;
    rtap_d   = rtap_q;
    rcount_d = rcount_q;
    rovf_d   = rovf_q;
`ifdef RING_METER_SWEEP_EN
    sweep_d  = sweep_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          phase_d = '0;
          ena_d   = 1'b1;
          busy_d  = 1'b1;
`ifdef RING_METER_SWEEP_EN
          sweep_d = sweep;
          tap_d   = sweep ? 4'd0 : tap_sel;
`else
          tap_d   = tap_sel;
`endif
        end
      end
      SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_d = GATE;
          phase_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GATE: begin
        cnt_d = cnt_next;
        ovf_d = ovf_next;
        if (phase_q == GATE_LAST) begin
          state_d  = REPORT;
          rvalid_d = 1'b1;
          rtap_d   = tap_q;
          rcount_d = cnt_next;
          rovf_d   = ovf_next;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      REPORT: begin
`ifdef RING_METER_SWEEP_EN
        if (sweep_q && (tap_q != 4'd15)) begin
          state_d = SETTLE;
          phase_d = '0;
          tap_d   = tap_q + 4'd1;
        end else begin
          state_d = IDLE;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
        end
`else
        state_d = IDLE;
        ena_d   = 1'b0;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      tap_d    = tap_q;
      ena_d    = 1'b0;
      busy_d   = 1'b0;
      rvalid_d = 1'b0;
      rtap_d   = rtap_q;
      rcount_d = rcount_q;
      rovf_d   = rovf_q;
    end
  end

  // State, synchroniser and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      tap_q    <= '0;
      ena_q    <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rtap_q   <= '0;
      rcount_q <= '0;
      rovf_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
`ifdef RING_METER_SWEEP_EN
      sweep_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      tap_q    <= tap_d;
      ena_q    <= ena_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rtap_q   <= rtap_d;
      rcount_q <= rcount_d;
      rovf_q   <= rovf_d;
      s1_q     <= ring_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
`ifdef RING_METER_SWEEP_EN
      sweep_q  <= sweep_d;
`endif
    end
  end

  assign ring_ena     = ena_q;
  assign ring_tap     = tap_q;
  assign busy         = busy_q;
  assign result_valid = rvalid_q;
  assign result_tap   = rtap_q;
  assign result_count = rcount_q;
  assign result_ovf   = rovf_q;

endmodule
